seg7_capture: RTL and testbench
===============================

# seg7_capture

Receive-side monitor for the multiplexed, active-low seven-segment display bus driven by the board's hex-digit display path. It samples the anode-select and segment lines, waits for each pattern to settle, and decodes segment patterns back to 4-bit hex values per digit. It also flags blank, unrecognised and malformed bus states. It sits in the test harness and self-check logic, alongside the display driver, so digit contents can be checked without a camera or a human.

## Interface
- `NDIG`, 8: number of multiplexed digits; 1..16.
- `STABLE_CYC`, 4: consecutive identical samples required before a capture; 2..255.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `an`  in  NDIG  anode select, active-low; bit i low selects digit i.
- `seg`  in  8  segment lines, active-low; bit7..bit1 = a..g, bit0 = dp.
- `clr`  in  1  one-cycle pulse; clears all sticky error flags.
- `digits`  out  4*NDIG  decoded hex value; digit i in bits [4i+3:4i].
- `dvalid`  out  NDIG  digit i has held a recognised pattern since its last capture.
- `dp`  out  NDIG  decimal point lit at the last capture of digit i.
- `blank`  out  NDIG  the last capture of digit i was all segments off.
- `bad`  out  NDIG  sticky; digit i received an unrecognised pattern.
- `bus_err`  out  1  sticky; multi-hot anode pattern held stable.
- `upd`  out  1  one-cycle pulse on every capture.
- `upd_idx`  out  4  index of the digit captured with `upd`.

## Operation
- **Input register.** `{an,seg}` is registered into `r0` every cycle, then copied into `r1` on the next cycle.
- **Stability counter `run`.**
  - `r0 == r1` → `run` increments, saturating at `STABLE_CYC`.
  - Otherwise → `run` = 1.
- **Capture rule.** A capture fires exactly once per run: on the cycle `run` becomes `STABLE_CYC`. A saturated run never recaptures.
- **Capture by anode class.**
  - One-hot (exactly one bit low) → capture digit at that index.
  - All ones → silently ignored; no `upd`.
  - Two or more bits low → set `bus_err`; no `upd`.
- **Decode.** Match `seg[7:1]` against the active-low table (value: pattern with dp off, `seg[7:0]`):
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:09, A:11, b:C1, C:63, d:85, E:61, F:71
  - `seg[0]` == 0 means dp lit.
- **Digit i update on capture.**
  - Match → `digits[i]` = value, `dvalid[i]` = 1, `blank[i]` = 0, `dp[i]` = ~`seg[0]`.
  - `seg[7:1]` all ones → `blank[i]` = 1, `dvalid[i]` = 0, `dp[i]` = ~`seg[0]`, `digits[i]` unchanged.
  - Anything else → `bad[i]` = 1, `dvalid[i]` = 0, `blank[i]` = 0, `digits[i]` and `dp[i]` unchanged.
- **`upd` / `upd_idx`.** Asserted for every one-hot capture (match, blank or bad).
- **`clr`.** Clears `bad` and `bus_err`. If a capture sets a flag on the same edge, set wins.
- **Reset value of every output.** All zero, including `upd_idx`. `r0`, `r1` and `run` are also zeroed.
- **Reset mid-run.** The in-progress run is discarded. A new run starts from the first post-reset sample, so no capture occurs earlier than `STABLE_CYC` + 1 edges after reset deasserts.

## Timing
- **Capture latency.**
  - A value first present at edge k is in `r0` after edge k.
  - `run` = `STABLE_CYC` after edge k+`STABLE_CYC`-1.
  - Outputs and `upd` update at edge k+`STABLE_CYC`.
- **Minimum stable width.** A value held for fewer than `STABLE_CYC` edges produces no capture and no flag.
- **Back-to-back digits.** With a scan period ≥ `STABLE_CYC`, one `upd` per digit slot.
- **`upd`.** High for exactly one cycle per capture.
- **Counter width.** `run` is clog2(`STABLE_CYC`+1) bits; it never wraps.

## Test plan
- **Single digit.** `STABLE_CYC`=4, `NDIG`=8; after reset hold `an`=FE, `seg`=25 for 10 cycles → exactly one `upd`, `upd_idx`=0, `digits[3:0]`=2, `dvalid[0]`=1, `dp[0]`=0, 4 edges after first sample.
- **Full scan.** Scan digits 0..7 with values 0..7, dp on digit 3 (`seg` 0C), 6 cycles per slot → 8 `upd` pulses; `digits`=32'h76543210; `dp`=8'h08.
- **Glitch and blank.** Hold `an`=FD, `seg`=71 for 3 cycles → no `upd`. Then `seg`=FF for 5 cycles → `upd`, `blank[1]`=1, `dvalid[1]`=0.
- **Bad pattern and `clr`.** `an`=7F, `seg`=55 held 5 cycles → `bad[7]`=1, `digits[31:28]` unchanged. Pulse `clr` → `bad`=0. Pulse `clr` on the same edge as a new bad capture → `bad[7]` stays 1.
- **Bus states.** `an`=FC held 5 cycles → `bus_err`=1, no `upd`. `an`=FF held 20 cycles → nothing changes.
- **Reset mid-run.** Assert `rst` during cycle 2 of a stable run → all outputs 0. The pattern held afterwards captures exactly `STABLE_CYC` + 1 edges after `rst` deasserts.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed active-low 7-segment bus and decodes each digit back to hex.
// Latency: a value first sampled at edge k is captured and reflected on the outputs at edge k+STABLE_CYC.
// Backpressure: none; this is a passive monitor, and captures are never stalled or dropped.
// Ports: an/seg are the sampled bus. clr clears the sticky bad/bus_err flags.
//        digits/dvalid/dp/blank/bad hold per-digit state. bus_err flags a multi-hot anode.
//        upd/upd_idx pulse once per one-hot capture.
module seg7_capture #(
   parameter int NDIG       = 8,
   parameter int STABLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NDIG-1:0]   an,
   input  logic [7:0]        seg,
   input  logic              clr,
   output logic [4*NDIG-1:0] digits,
   output logic [NDIG-1:0]   dvalid,
   output logic [NDIG-1:0]   dp,
   output logic [NDIG-1:0]   blank,
   output logic [NDIG-1:0]   bad,
   output logic              bus_err,
   output logic              upd,
   output logic [3:0]        upd_idx
);

   localparam int W  = NDIG + 8;
   localparam int RW = $clog2(STABLE_CYC + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYC);

   logic [W-1:0]      r0_q, r0_d, r1_q, r1_d;
   logic [RW-1:0]     run_q, run_d;
   logic              cap_q, cap_d;
   logic [4*NDIG-1:0] digits_q, digits_d;
   logic [NDIG-1:0]   dvalid_q, dvalid_d, dp_q, dp_d, blank_q, blank_d, bad_q, bad_d;
   logic              bus_err_q, bus_err_d, upd_q, upd_d;
   logic [3:0]        upd_idx_q, upd_idx_d;

   logic [NDIG-1:0]   cap_an;
   logic [7:0]        cap_seg;
   logic [4:0]        lo_cnt;
   logic [3:0]        lo_idx;
   logic [4:0]        dec;
   int                idx;

   // Active-low pattern (dp off) to {hit, value}.
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      r = 5'h00;
      case ({p, 1'b1})
         8'h03: r = 5'h10;
         8'h9F: r = 5'h11;
         8'h25: r = 5'h12;
         8'h0D: r = 5'h13;
         8'h99: r = 5'h14;
         8'h49: r = 5'h15;
         8'h41: r = 5'h16;
         8'h1F: r = 5'h17;
         8'h01: r = 5'h18;
         8'h09: r = 5'h19;
         8'h11: r = 5'h1A;
         8'hC1: r = 5'h1B;
         8'h63: r = 5'h1C;
         8'h85: r = 5'h1D;
         8'h61: r = 5'h1E;
         8'h71: r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // Stability tracking. run reflects whether r0 == r1 after this edge, so it
   // is computed from the values about to be loaded rather than the old ones.
   always_comb begin
      r0_d = {an, seg};
      r1_d = r0_q;
      if (r0_d == r1_d) begin
         run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end else begin
         run_d = RW'(1);
      end
      // Fire only on the transition into saturation, so a held value captures once.
      cap_d = (run_d == RUN_MAX) && (run_q != RUN_MAX);
   end

   // Anode classification of the settled sample in r1.
   always_comb begin
      cap_an  = r1_q[W-1:8];
      cap_seg = r1_q[7:0];
      lo_cnt  = 5'd0;
      lo_idx  = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (!cap_an[i]) begin
            lo_cnt = lo_cnt + 5'd1;
            lo_idx = i[3:0];
         end
      end
      idx = int'(lo_idx);
      dec = decode(cap_seg[7:1]);
   end

   always_comb begin
      digits_d  = digits_q;
      dvalid_d  = dvalid_q;
      dp_d      = dp_q;
      blank_d   = blank_q;
      upd_d     = 1'b0;
      upd_idx_d = upd_idx_q;
      // clr is applied first so a flag set by a capture on the same edge survives.
      bad_d     = clr ? '0 : bad_q;
      bus_err_d = clr ? 1'b0 : bus_err_q;
      if (cap_q) begin
         if (lo_cnt == 5'd1) begin
            upd_d     = 1'b1;
            upd_idx_d = lo_idx;
            if (dec[4]) begin
               digits_d[4*idx +: 4] = dec[3:0];
               dvalid_d[idx]        = 1'b1;
               blank_d[idx]         = 1'b0;
               dp_d[idx]            = ~cap_seg[0];
            end else if (&cap_seg[7:1]) begin
               blank_d[idx]  = 1'b1;
               dvalid_d[idx] = 1'b0;
               dp_d[idx]     = ~cap_seg[0];
            end else begin
               bad_d[idx]    = 1'b1;
               dvalid_d[idx] = 1'b0;
               blank_d[idx]  = 1'b0;
            end
         end else if (lo_cnt >= 5'd2) begin
            bus_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r0_q      <= '0;
         r1_q      <= '0;
         run_q     <= '0;
         cap_q     <= 1'b0;
         digits_q  <= '0;
         dvalid_q  <= '0;
         dp_q      <= '0;
         blank_q   <= '0;
         bad_q     <= '0;
         bus_err_q <= 1'b0;
         upd_q     <= 1'b0;
         upd_idx_q <= 4'd0;
      end else begin
         r0_q      <= r0_d;
         r1_q      <= r1_d;
         run_q     <= run_d;
         cap_q     <= cap_d;
         digits_q  <= digits_d;
         dvalid_q  <= dvalid_d;
         dp_q      <= dp_d;
         blank_q   <= blank_d;
         bad_q     <= bad_d;
         bus_err_q <= bus_err_d;
         upd_q     <= upd_d;
         upd_idx_q <= upd_idx_d;
      end
   end

   assign digits  = digits_q;
   assign dvalid  = dvalid_q;
   assign dp      = dp_q;
   assign blank   = blank_q;
   assign bad     = bad_q;
   assign bus_err = bus_err_q;
   assign upd     = upd_q;
   assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: drives held {an,seg} segments and predicts each capture from segment lengths.
// Latency: every expected capture carries the edge number it must appear on.
// Backpressure: none; the monitor pops one expectation per upd pulse.
module tb_seg7_capture;
   localparam int NDIG = 8;
   localparam int S    = 4;

   logic        clk = 1'b0;
   logic        rst, clr;
   logic [7:0]  an, seg;
   logic [31:0] digits;
   logic [7:0]  dvalid, dp, blank, bad;
   logic        bus_err, upd;
   logic [3:0]  upd_idx;

   seg7_capture #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .an(an), .seg(seg), .clr(clr),
      .digits(digits), .dvalid(dvalid), .dp(dp), .blank(blank), .bad(bad),
      .bus_err(bus_err), .upd(upd), .upd_idx(upd_idx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] tbl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

   typedef struct {
      int          c;
      logic [3:0]  idx;
      logic [31:0] dig;
      logic [7:0]  dv, dpv, bl, bd;
   } exp_t;
   exp_t q[$];

   // Reference state: what the display outputs should read after every capture so far.
   logic [31:0] m_dig;
   logic [7:0]  m_dv, m_dp, m_bl, m_bd;
   logic        m_be;
   logic [3:0]  m_idx;

   task automatic model_reset();
      m_dig = '0; m_dv = '0; m_dp = '0; m_bl = '0; m_bd = '0; m_be = 1'b0; m_idx = '0;
   endtask

   task automatic model_clr();
      m_bd = '0;
      m_be = 1'b0;
   endtask

   function automatic int lookup(input logic [7:0] s);
      for (int k = 0; k < 16; k++) if ((s | 8'h01) == tbl[k]) return k;
      return -1;
   endfunction

   task automatic model_capture(input logic [7:0] a, input logic [7:0] s, input int ce);
      int nz, id, v;
      exp_t e;
      nz = 0; id = 0;
      for (int k = 0; k < NDIG; k++) if (!a[k]) begin nz++; id = k; end
      if (nz == 0) return;
      if (nz >= 2) begin m_be = 1'b1; return; end
      v = lookup(s);
      if (v >= 0) begin
         m_dig[4*id +: 4] = v[3:0];
         m_dv[id] = 1'b1; m_bl[id] = 1'b0; m_dp[id] = ~s[0];
      end else if ((s | 8'h01) == 8'hFF) begin
         m_bl[id] = 1'b1; m_dv[id] = 1'b0; m_dp[id] = ~s[0];
      end else begin
         m_bd[id] = 1'b1; m_dv[id] = 1'b0; m_bl[id] = 1'b0;
      end
      m_idx = id[3:0];
      e.c = ce; e.idx = m_idx; e.dig = m_dig; e.dv = m_dv; e.dpv = m_dp; e.bl = m_bl; e.bd = m_bd;
      q.push_back(e);
   endtask

   // Hold {a,s} for d sampled edges; clr pulses on the edge at offset clr_off (-1 = none).
   // A held segment of length >= S captures on the S-th edge after its first sample.
   task automatic drive(input logic [7:0] a, input logic [7:0] s, input int d, input int clr_off);
      int t0;
      t0 = cyc + 1;
      if (d >= S) begin
         if (clr_off >= 0 && clr_off <= S) begin
            model_clr();
            model_capture(a, s, t0 + S);
         end else begin
            model_capture(a, s, t0 + S);
            if (clr_off >= 0) model_clr();
         end
      end else if (clr_off >= 0) begin
         model_clr();
      end
      for (int i = 0; i < d; i++) begin
         an = a; seg = s; clr = (i == clr_off);
         @(negedge clk);
      end
      clr = 1'b0;
   endtask

   task automatic idle(input int d);
      drive(8'hFF, 8'hFF, d, -1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_all(input string name);
      chk({name, ".digits"},  digits,          m_dig);
      chk({name, ".dvalid"},  {24'd0, dvalid}, {24'd0, m_dv});
      chk({name, ".dp"},      {24'd0, dp},     {24'd0, m_dp});
      chk({name, ".blank"},   {24'd0, blank},  {24'd0, m_bl});
      chk({name, ".bad"},     {24'd0, bad},    {24'd0, m_bd});
      chk({name, ".bus_err"}, {31'd0, bus_err}, {31'd0, m_be});
      chk({name, ".upd"},     {31'd0, upd},     32'd0);
      chk({name, ".upd_idx"}, {28'd0, upd_idx}, {28'd0, m_idx});
   endtask

   // Monitor: every upd pulse must match the oldest outstanding expectation, on its predicted edge.
   always @(negedge clk) begin
      if (!rst && upd) begin
         n_chk++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL upd_unexpected: upd_idx=%0d at cycle %0d, none expected", upd_idx, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.c != cyc || upd_idx !== e.idx || digits !== e.dig || dvalid !== e.dv ||
                dp !== e.dpv || blank !== e.bl || bad !== e.bd) begin
               n_err++;
               $display("FAIL upd_cmp: cyc=%0d idx=%0d dig=%h dv=%h dp=%h bl=%h bd=%h expected cyc=%0d idx=%0d dig=%h dv=%h dp=%h bl=%h bd=%h",
                        cyc, upd_idx, digits, dvalid, dp, blank, bad,
                        e.c, e.idx, e.dig, e.dv, e.dpv, e.bl, e.bd);
            end
         end
      end
   end

   initial begin
      logic [7:0] pa, ps, a, s;
      int d, co, r;
      rst = 1'b1; clr = 1'b0; an = 8'hFF; seg = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      // Single digit: '2' on digit 0.
      drive(8'hFE, 8'h25, 10, -1);
      idle(S + 2);
      check_all("single");
      chk("single.nibble", {28'd0, digits[3:0]}, 32'd2);

      // Full scan, '3' with dp lit.
      for (int i = 0; i < 8; i++) begin
         a = ~(8'h01 << i);
         s = tbl[i];
         if (i == 3) s = s & 8'hFE;
         drive(a, s, 6, -1);
      end
      idle(S + 2);
      check_all("scan");
      chk("scan.digits", digits, 32'h76543210);
      chk("scan.dp", {24'd0, dp}, 32'h08);

      // Glitch shorter than S, then a blank.
      drive(8'hFD, 8'h71, 3, -1);
      drive(8'hFD, 8'hFF, 5, -1);
      idle(S + 2);
      check_all("blank");
      chk("blank.bit1", {31'd0, blank[1]}, 32'd1);

      // Bad pattern, clr, then clr coinciding with a new bad capture.
      drive(8'h7F, 8'h55, 5, -1);
      idle(S + 2);
      check_all("bad_set");
      chk("bad_set.digit7", {28'd0, digits[31:28]}, 32'd7);
      drive(8'hFF, 8'hFF, 3, 1);
      check_all("bad_clr");
      drive(8'h7F, 8'h55, 5, S);
      idle(S + 2);
      check_all("bad_same_edge");
      chk("bad_same_edge.bit7", {31'd0, bad[7]}, 32'd1);

      // Multi-hot anodes, then a long all-off stretch.
      drive(8'hFC, 8'h25, 5, -1);
      idle(20);
      check_all("bus");
      chk("bus.err", {31'd0, bus_err}, 32'd1);

      // Reset in the middle of a stable run.
      chk("pre_reset.queue", q.size(), 32'd0);
      an = 8'hFB; seg = 8'h0D;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check_all("midrun_reset");
      rst = 1'b0;
      drive(8'hFB, 8'h0D, 6, -1);
      idle(S + 2);
      check_all("after_reset");

      // Random segments; consecutive segments always differ so runs never merge.
      pa = 8'hFF; ps = 8'hFF;
      for (int n = 0; n < 400; n++) begin
         do begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = ~(8'h01 << $urandom_range(0, 7));
            else if (r == 7) a = 8'hFF;
            else             a = 8'($urandom);
            r = $urandom_range(0, 19);
            if (r < 12)      s = tbl[$urandom_range(0, 15)] & {7'h7F, 1'($urandom)};
            else if (r < 15) s = {7'h7F, 1'($urandom)};
            else             s = 8'($urandom);
         end while ({a, s} == {pa, ps});
         d  = $urandom_range(1, 7);
         co = (d >= 2 && $urandom_range(0, 9) == 0) ? $urandom_range(1, d - 1) : -1;
         drive(a, s, d, co);
         pa = a; ps = s;
         if (n % 50 == 49) begin
            idle(S + 2);
            pa = 8'hFF; ps = 8'hFF;
            check_all("random");
         end
      end
      idle(S + 2);
      chk("final.queue", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
